fetch_group_queue: RTL and testbench

Stage directly downstream of the next-PC stage. It registers each fetch group the next-PC stage launches and captures the I-cache data for it one cycle later. It sequences I-cache miss wait and replay, and buffers completed groups in a small FIFO that feeds decode through a valid/ready handshake. Back-pressure to the next-PC stage uses a credit rule, so a launched group is never dropped. A recovery flush empties the whole block and accepts the redirected group in the same cycle.

---
 rtl/fetch_group_queue.sv | 174 +++++++++++++++++
 tb/tb_fetch_group_queue.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_group_queue.sv
// Purpose: registers each launched fetch group, captures its I-cache data, sequences miss/replay, buffers groups for decode.
// Latency: launch to out_valid is 2 cycles on a hit; ic_refillDone to out_valid is 3 cycles on a miss.
// Backpressure: in_ready is a conservative credit (stage S + FIFO count <= depth-1); decode side is valid/ready.
module fetch_group_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int PC_WIDTH    = 32,
  parameter int INSN_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [PC_WIDTH-1:0]               in_pc,
  input  logic [FETCH_WIDTH-1:0]            in_slotValid,
  output logic                              in_ready,
  input  logic                              ic_hit,
  input  logic [FETCH_WIDTH*INSN_WIDTH-1:0] ic_data,
  input  logic                              ic_refillDone,
  output logic                              ic_replayReq,
  output logic [PC_WIDTH-1:0]               replay_pc,
  input  logic                              flush,
  output logic                              out_valid,
  output logic [PC_WIDTH-1:0]               out_pc,
  output logic [FETCH_WIDTH-1:0]            out_slotValid,
  output logic [FETCH_WIDTH*INSN_WIDTH-1:0] out_insn,
  input  logic                              out_ready
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = FETCH_WIDTH * INSN_WIDTH;
  localparam logic [CW:0]   LIMIT = (CW+1)'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] FULL  = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MISS   = 2'd1,
    ST_REPLAY = 2'd2
  } state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [FETCH_WIDTH-1:0] slot_vld;
    logic [DW-1:0]          insn;
  } grp_t;

  state_e                 state_q, state_d;
  logic                   s_vld_q, s_vld_d;
  logic [PC_WIDTH-1:0]    s_pc_q, s_pc_d;
  logic [FETCH_WIDTH-1:0] s_slot_q, s_slot_d;
  logic [AW-1:0]          head_q, head_d;
  logic [AW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  grp_t                   mem_q [QUEUE_DEPTH];
  grp_t                   wr_grp_d;

  logic        s_miss;
  logic [CW:0] credit_used;
  logic        credit_ok;
  logic        load;
  logic        push;
  logic        pop;

  // Per-cycle qualifiers: miss hazard, credit, launch accept, FIFO push/pop (flush and reset suppress both)
  always_comb begin
    s_miss      = s_vld_q && !ic_hit;
    credit_used = {1'b0, count_q} + {{CW{1'b0}}, s_vld_q};
    credit_ok   = (credit_used <= LIMIT);
    if (!rst) begin
      in_ready = 1'b0;
    end else if (flush) begin
      in_ready = 1'b1;
    end else begin
      in_ready = (state_q == ST_RUN) && !s_miss && credit_ok;
    end
    load     = in_valid && in_ready;
    push     = rst && !flush && (state_q == ST_RUN) && s_vld_q && ic_hit;
    pop      = rst && !flush && (count_q != '0) && out_ready;
    wr_grp_d = '{pc: s_pc_q, slot_vld: s_slot_q, insn: ic_data};
  end

  // Stage register S: a new launch wins; otherwise a write-out or flush empties it; a miss holds it
  always_comb begin
    s_vld_d  = s_vld_q;
    s_pc_d   = s_pc_q;
    s_slot_d = s_slot_q;
    if (load) begin
      s_vld_d  = 1'b1;
      s_pc_d   = in_pc;
      s_slot_d = in_slotValid;
    end else if (flush || push) begin
      s_vld_d  = 1'b0;
    end
  end

  // Miss sequencer next state; a refill pulse only matters while waiting in MISS
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:    if (s_miss) state_d = ST_MISS;
        ST_MISS:   if (ic_refillDone) state_d = ST_REPLAY;
        ST_REPLAY: state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // Miss sequencer outputs: replay the held PC for exactly the REPLAY cycle
  always_comb begin
    ic_replayReq = (state_q == ST_REPLAY);
    replay_pc    = s_pc_q;
  end

  // FIFO pointer and occupancy update; flush empties it outright
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head entry drives decode straight from storage flops
  always_comb begin
    out_valid     = (count_q != '0);
    out_pc        = mem_q[head_q].pc;
    out_slotValid = mem_q[head_q].slot_vld;
    out_insn      = mem_q[head_q].insn;
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      s_vld_q  <= 1'b0;
      s_pc_q   <= '0;
      s_slot_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_vld_q  <= s_vld_d;
      s_pc_q   <= s_pc_d;
      s_slot_q <= s_slot_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= wr_grp_d;
  end

  // The credit rule must make a write into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && (count_q == FULL)));

endmodule

// File: tb/tb_fetch_group_queue.sv
// Purpose: randomized and directed stimulus for fetch_group_queue with an in-order group scoreboard.
// Latency: checks hit latency of 2 and refill-to-output latency of 3 in directed phases.
// Backpressure: drives out_ready patterns and checks the credit limit admits exactly QUEUE_DEPTH groups.
module tb_fetch_group_queue;
  localparam int FW = 2;
  localparam int PW = 32;
  localparam int IW = 32;
  localparam int QD = 4;
  localparam int DW = FW * IW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_pc = '0;
  logic [FW-1:0] in_slotValid = '0;
  logic          in_ready;
  logic          ic_hit = 1'b0;
  logic [DW-1:0] ic_data = '0;
  logic          ic_refillDone = 1'b0;
  logic          ic_replayReq;
  logic [PW-1:0] replay_pc;
  logic          flush = 1'b0;
  logic          out_valid;
  logic [PW-1:0] out_pc;
  logic [FW-1:0] out_slotValid;
  logic [DW-1:0] out_insn;
  logic          out_ready = 1'b0;

  fetch_group_queue #(.FETCH_WIDTH(FW), .PC_WIDTH(PW), .INSN_WIDTH(IW), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_slotValid(in_slotValid), .in_ready(in_ready),
    .ic_hit(ic_hit), .ic_data(ic_data), .ic_refillDone(ic_refillDone),
    .ic_replayReq(ic_replayReq), .replay_pc(replay_pc),
    .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_slotValid(out_slotValid), .out_insn(out_insn),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pc;
    logic [FW-1:0] sv;
    logic [DW-1:0] insn;
    int            cyc;
  } grp_t;

  grp_t          exp_q[$];
  int            nchk = 0;
  int            nerr = 0;
  int            cyc = 0;
  int            tick_cyc = 0;
  int            lat_exp = -1;
  int            pop_cnt = 0;
  int            last_pop_cyc = 0;
  int            replay_cnt = 0;
  int            max_out = 0;
  int            accepts = 0;
  logic          launched = 1'b0;
  logic          rdy_seen = 1'b0;
  logic [PW-1:0] last_pop_pc = '0;
  logic [PW-1:0] last_replay_pc = '0;
  logic [PW-1:0] last_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction image of the cache: every PC maps to a fixed, distinct bit pattern
  function automatic logic [DW-1:0] insn_of(input logic [PW-1:0] pc);
    logic [DW-1:0] d;
    for (int i = 0; i < FW; i++)
      d[i*IW +: IW] = (pc * 32'd2654435761) ^ (32'h1111_0000 * 32'(i + 1)) ^ (pc + 32'(i));
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // One cycle: cache returns data for last cycle's address, the model records accepted launches
  task automatic tick();
    tick_cyc = cyc;
    ic_data  = ic_hit ? insn_of(last_addr) : ~insn_of(last_addr);
    #1;
    rdy_seen = in_ready;
    launched = rst && in_valid && in_ready;
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (flush) exp_q.delete();
      if (launched) begin
        exp_q.push_back('{pc: in_pc, sv: in_slotValid, insn: insn_of(in_pc), cyc: cyc});
        accepts++;
      end
      if (ic_replayReq) begin
        replay_cnt++;
        last_replay_pc = replay_pc;
      end
    end
    if (launched) last_addr = in_pc;
    else if (rst && ic_replayReq) last_addr = replay_pc;
    if (exp_q.size() > max_out) max_out = exp_q.size();
    @(negedge clk);
  endtask

  task automatic set_idle();
    in_valid      = 1'b0;
    flush         = 1'b0;
    ic_refillDone = 1'b0;
    ic_hit        = 1'b1;
    out_ready     = 1'b1;
  endtask

  // Monitor: pops the model whenever decode consumes a head group
  initial begin
    grp_t g;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_output: got pc %0h, expected no group", out_pc);
        end else begin
          g = exp_q.pop_front();
          check("out_pc", out_pc, g.pc);
          check("out_slotValid", out_slotValid, g.sv);
          check("out_insn", out_insn, g.insn);
          if (lat_exp >= 0) check("hit_latency", cyc - g.cyc, lat_exp);
          pop_cnt++;
          last_pop_cyc = cyc;
          last_pop_pc  = out_pc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   p0, a0, rc0, r_cyc, n;
    logic rdy_all, rdy_any;
    logic [PW-1:0] pc;

    @(negedge clk);
    // Reset state
    rst = 1'b0;
    set_idle();
    tick();
    tick();
    check("rst_in_ready", rdy_seen, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_replayReq", ic_replayReq, 0);
    check("rst_replay_pc", replay_pc, 0);
    rst = 1'b1;
    tick();
    check("rst_release_in_ready", rdy_seen, 1);

    // Streaming hits
    set_idle();
    lat_exp = 2;
    rdy_all = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid     = 1'b1;
      in_pc        = 32'h1000 + PW'(8 * i);
      in_slotValid = FW'(i + 1);
      tick();
      rdy_all &= rdy_seen;
    end
    in_valid = 1'b0;
    repeat (3) tick();
    lat_exp = -1;
    check("stream_in_ready", rdy_all, 1);
    check("stream_pops", pop_cnt - p0, 3);
    check("stream_last_pc", last_pop_pc, 32'h1010);

    // Miss and replay
    set_idle();
    rc0 = replay_cnt;
    in_valid = 1'b1; in_pc = 32'h2000; in_slotValid = 2'b01;
    tick();
    in_valid = 1'b0;
    ic_hit   = 1'b0;
    rdy_any  = 1'b0;
    tick();
    rdy_any |= rdy_seen;
    for (int i = 0; i < 4; i++) begin
      ic_hit = 1'($urandom);
      tick();
      rdy_any |= rdy_seen;
    end
    ic_refillDone = 1'b1;
    ic_hit        = 1'b0;
    tick();
    r_cyc = tick_cyc;
    rdy_any |= rdy_seen;
    ic_refillDone = 1'b0;
    tick();
    rdy_any |= rdy_seen;
    ic_hit = 1'b1;
    repeat (4) tick();
    check("miss_in_ready_low", rdy_any, 0);
    check("miss_replay_count", replay_cnt - rc0, 1);
    check("miss_replay_pc", last_replay_pc, 32'h2000);
    check("miss_out_pc", last_pop_pc, 32'h2000);
    check("miss_refill_to_out", last_pop_cyc - r_cyc, 3);

    // Back-pressure: credit admits exactly QD groups
    set_idle();
    out_ready = 1'b0;
    a0 = accepts;
    pc = 32'h4000;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = pc; in_slotValid = 2'b11;
      tick();
      if (launched) pc = pc + 32'h8;
    end
    check("bp_accepts", accepts - a0, QD);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    p0 = pop_cnt;
    repeat (8) tick();
    check("bp_drained", pop_cnt - p0, QD);
    check("bp_empty", out_valid, 0);

    // Flush while in MISS with two groups queued
    set_idle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h5000 + PW'(8 * i); in_slotValid = 2'b11;
      tick();
    end
    in_valid = 1'b0;
    ic_hit   = 1'b0;
    tick();
    tick();
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3000; in_slotValid = 2'b10;
    p0 = pop_cnt;
    tick();
    check("flush_in_ready", rdy_seen, 1);
    flush = 1'b0; in_valid = 1'b0; ic_hit = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    rc0 = replay_cnt;
    ic_refillDone = 1'b1;
    tick();
    ic_refillDone = 1'b0;
    repeat (4) tick();
    check("flush_pops", pop_cnt - p0, 1);
    check("flush_out_pc", last_pop_pc, 32'h3000);
    check("flush_stray_refill", replay_cnt - rc0, 0);
    check("flush_empty", out_valid, 0);

    // Pointer wrap with out_ready toggling
    set_idle();
    a0 = accepts;
    p0 = pop_cnt;
    n  = 0;
    while ((accepts - a0) < 10 && n < 100) begin
      in_valid = 1'b1; in_pc = 32'h6000 + PW'(16 * (accepts - a0)); in_slotValid = 2'($urandom);
      out_ready = n[0];
      tick();
      n++;
    end
    if (n >= 100) begin
      nchk++; nerr++;
      $display("FAIL wrap_accept_timeout: got %0d groups, expected 10", accepts - a0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    check("wrap_pops", pop_cnt - p0, 10);

    // Reset mid-stream with three groups queued
    set_idle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h7000 + PW'(8 * i); in_slotValid = 2'b11;
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0; in_valid = 1'b1; in_pc = 32'h7100;
    tick();
    check("midrst_in_ready", rdy_seen, 0);
    rst = 1'b1; in_valid = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_replay_pc", replay_pc, 0);
    tick();
    check("midrst_release_ready", rdy_seen, 1);

    // Reset mid-miss: later refill pulse must not replay
    set_idle();
    in_valid = 1'b1; in_pc = 32'h7200; in_slotValid = 2'b11;
    tick();
    in_valid = 1'b0; ic_hit = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rc0 = replay_cnt;
    ic_refillDone = 1'b1;
    tick();
    ic_refillDone = 1'b0; ic_hit = 1'b1;
    repeat (3) tick();
    check("rstmiss_no_replay", replay_cnt - rc0, 0);
    check("rstmiss_empty", out_valid, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid      = ($urandom % 4) != 0;
      in_pc         = $urandom;
      in_slotValid  = 2'($urandom);
      ic_hit        = ($urandom % 10) < 7;
      ic_refillDone = ($urandom % 5) == 0;
      flush         = ($urandom % 40) == 0;
      out_ready     = ($urandom % 10) < 7;
      tick();
    end
    set_idle();
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      ic_refillDone = ($urandom % 3) == 0;
      tick();
      n++;
    end
    ic_refillDone = 1'b0;
    repeat (3) tick();
    check("random_drain", exp_q.size(), 0);
    check("outstanding_bound", (max_out <= QD), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
